// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs and services the interval timer's s1 register slave:
// period/control setup, timeout acknowledge with tick counting, counter snapshots and stop.
module timer_ctrl_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        snap_req,
    input  logic [31:0] cfg_period,
    input  logic        cfg_continuous,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [31:0] snapshot,
    output logic        snap_valid,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    input  logic        m_irq
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST,
        SNAP_W, RD_L_A, RD_L_D, RD_H_A, RD_H_D, WR_STOP
    } state_t;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    state_t      state;
    logic [31:0] period_q;
    logic        cont_q;
    logic        stop_pending;
    logic [15:0] snap_lo;

    // Bus outputs are loaded together with the next state, so each state's access
    // appears on the bus during the cycle the FSM sits in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            period_q     <= 32'd0;
            cont_q       <= 1'b0;
            stop_pending <= 1'b0;
            snap_lo      <= 16'd0;
            busy         <= 1'b0;
            tick         <= 1'b0;
            tick_count   <= 16'd0;
            snapshot     <= 32'd0;
            snap_valid   <= 1'b0;
            m_address    <= 3'd0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= 16'd0;
        end else begin
            tick         <= 1'b0;
            snap_valid   <= 1'b0;
            m_address    <= 3'd0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= 16'd0;

            case (state)
                IDLE: begin
                    if (start && (cfg_period != 32'd0)) begin
                        period_q     <= cfg_period;
                        cont_q       <= cfg_continuous;
                        tick_count   <= 16'd0;
                        busy         <= 1'b1;
                        state        <= WR_PL;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_PERIODL;
                        m_writedata  <= cfg_period[15:0];
                    end
                end
                WR_PL: begin
                    state        <= WR_PH;
                    m_chipselect <= 1'b1;
                    m_write_n    <= 1'b0;
                    m_address    <= ADDR_PERIODH;
                    m_writedata  <= period_q[31:16];
                end
                // Control word: STOP=0, START=1, CONT, ITO=1
                WR_PH: begin
                    state        <= WR_CTRL;
                    m_chipselect <= 1'b1;
                    m_write_n    <= 1'b0;
                    m_address    <= ADDR_CONTROL;
                    m_writedata  <= {12'd0, 1'b0, 1'b1, cont_q, 1'b1};
                end
                WR_CTRL: begin
                    state <= RUN;
                end
                RUN: begin
                    if (stop) begin
                        state        <= WR_STOP;
                        stop_pending <= 1'b1;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_CONTROL;
                        m_writedata  <= 16'h0008;
                    end else if (m_irq) begin
                        state        <= CLR_ST;
                        stop_pending <= 1'b0;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_STATUS;
                    end else if (snap_req) begin
                        state        <= SNAP_W;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_SNAPL;
                    end
                end
                WR_STOP: begin
                    state        <= CLR_ST;
                    m_chipselect <= 1'b1;
                    m_write_n    <= 1'b0;
                    m_address    <= ADDR_STATUS;
                end
                // A stop also clears status so a late timeout cannot linger, but it is not a tick.
                CLR_ST: begin
                    stop_pending <= 1'b0;
                    if (stop_pending) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tick       <= 1'b1;
                        tick_count <= tick_count + 16'd1;
                        if (cont_q) begin
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                SNAP_W: begin
                    state        <= RD_L_A;
                    m_chipselect <= 1'b1;
                    m_address    <= ADDR_SNAPL;
                end
                RD_L_A: begin
                    state <= RD_L_D;
                end
                RD_L_D: begin
                    snap_lo      <= m_readdata;
                    state        <= RD_H_A;
                    m_chipselect <= 1'b1;
                    m_address    <= ADDR_SNAPH;
                end
                RD_H_A: begin
                    state <= RD_H_D;
                end
                RD_H_D: begin
                    snapshot   <= {m_readdata, snap_lo};
                    snap_valid <= 1'b1;
                    state      <= RUN;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/timer_ctrl_master.md
# timer_ctrl_master

Avalon-MM master that owns and drives the interval timer's 16-bit, 3-bit-address register slave on behalf of hardware logic with no CPU involvement. It programs period and control, services each timeout interrupt (status clear plus tick pulse and count), takes counter snapshots on request, and stops the timer on command. It sits between a host-side command interface and the timer's s1 port, sharing its clock.

## Interface
- No parameters; register map fixed: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; program cfg_period/cfg_continuous and start timer
- stop  in  1  pulse; stop running timer
- snap_req  in  1  pulse; capture and read timer counter
- cfg_period  in  32  period value written to period_h:period_l; sampled on accepted start
- cfg_continuous  in  1  control CONT bit; sampled on accepted start
- busy  out  1  high in any state other than IDLE
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  16  serviced timeouts since last accepted start
- snapshot  out  32  last captured counter value
- snap_valid  out  1  one-cycle pulse when snapshot updates
- m_address  out  3  timer register address
- m_chipselect  out  1  timer chipselect
- m_write_n  out  1  timer write strobe, active low
- m_writedata  out  16  timer write data
- m_readdata  in  16  timer read data, registered by slave (1-cycle latency)
- m_irq  in  1  timer interrupt

## Operation
- All outputs registered (Moore). Reset: state IDLE, busy 0, tick 0, tick_count 0, snapshot 0, snap_valid 0, m_chipselect 0, m_write_n 1, m_address 0, m_writedata 0.
- Idle bus: chipselect 0, write_n 1, address 0, writedata 0. Every bus access is exactly one cycle; slave has no waitrequest.
- States: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, SNAP_W, RD_L_A, RD_L_D, RD_H_A, RD_H_D, WR_STOP.
- IDLE: start with cfg_period != 0 -> latch period/continuous, clear tick_count, -> WR_PL. start with cfg_period == 0 ignored. stop/snap_req ignored.
- WR_PL: write addr 2, data period[15:0] -> WR_PH: write addr 3, data period[31:16] -> WR_CTRL: write addr 1, data {STOP=0,START=1,CONT,ITO=1} (0x7 continuous, 0x5 one-shot) -> RUN.
- Period written before control: the slave's period write forces reload and stop; control START then runs from full period.
- RUN priority: stop > m_irq > snap_req.
  - stop -> WR_STOP: write addr 1 data 0x8 -> CLR_ST (no tick) -> IDLE.
  - m_irq -> CLR_ST: write addr 0 data 0; tick pulses next cycle, tick_count +1 (wraps 0xFFFF -> 0x0000); -> RUN if continuous else IDLE.
  - snap_req -> SNAP_W: write addr 4 data 0 -> RD_L_A -> RD_L_D -> RD_H_A -> RD_H_D -> RUN.
- Read: *_A drives addr (4 or 5), chipselect 1, write_n 1. *_D captures m_readdata into snapshot low/high half. snapshot updates atomically at RD_H_D exit; snap_valid pulses with update.
- start while busy ignored. stop/snap_req pulses arriving outside RUN (including config/snapshot sequences) dropped; no queuing.
- m_irq during a snapshot sequence is held by the slave and serviced on return to RUN.
- Reset mid-operation: bus returns idle immediately; timer state not otherwise restored.

## Timing
- start accepted -> WR_PL write in cycle +1, WR_PH +2, WR_CTRL +3, RUN at +4.
- m_irq sampled high in RUN cycle N -> status write in N+1, tick high in N+2; slave irq low from N+2, so a second service of one timeout is impossible.
- snap_req in RUN cycle N -> snap write N+1, snapshot/snap_valid visible N+6, RUN in N+6.
- stop in RUN cycle N -> control write N+1, status write N+2, IDLE and busy 0 at N+3.
- Minimum service interval 2 cycles; timer periods < 3 cycles may coalesce timeouts (slave limitation, not checked).

## Test plan
- Reset, then start, cfg_period 0x0001_86A0, continuous 1 -> writes (2,0x86A0),(3,0x0001),(1,0x7) on consecutive cycles; busy 1.
- Continuous run, timer model fires irq 3 times -> 3 status writes to addr 0, 3 tick pulses, tick_count 3, still RUN.
- One-shot (continuous 0), period 10 -> control 0x5; single tick, tick_count 1, IDLE, busy 0.
- snap_req in RUN, model counter 0x0001_2345 -> write addr 4, reads 4 then 5, snapshot 0x0001_2345, snap_valid one cycle.
- stop and m_irq same cycle in RUN -> control write 0x8, status clear, no tick, IDLE three cycles later.
- tick_count preset 0xFFFF via 65535 services -> next tick wraps to 0x0000; start with cfg_period 0 in IDLE ignored (no bus activity); reset asserted mid WR_PH -> bus idle immediately.
